branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped BTB entries; power of two, 2..256.
REQ-002 Parameter IDX_W, default 4, log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-003 Parameter CNT_W, default 32, width of each performance counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_pc  input  32  PC of the instruction in IF.
REQ-007 pred_pc  output  32  predicted next PC for if_pc; combinational.
REQ-008 id_valid  input  1  ID stage holds a real instruction.
REQ-009 id_stall  input  1  ID stage frozen this cycle.
REQ-010 id_instr  input  32  instruction in ID.
REQ-011 id_pc  input  32  PC of the instruction in ID.
REQ-012 id_pred_pc  input  32  pred_pc captured for this instruction when it was in IF.
REQ-013 GPR_rs_data, GPR_rt_data  input  32 each  forwarded rs/rt values in ID.
REQ-014 redirect  output  1  misprediction detected in ID; IF must flush and refetch.
REQ-015 redirect_pc  output  32  correct next PC; meaningful only when redirect=1.
REQ-016 branch_cnt, mispredict_cnt  output  CNT_W each  performance counters.

Function
REQ-017 Each BTB entry SHALL hold valid (1b), tag (30-IDX_W b), target (32b), counter (2b saturating).
REQ-018 pred_pc SHALL be the entry target when the if_pc entry is valid, tags match, and counter[1]=1 (or counter=2'b11 for jump-allocated entries); otherwise if_pc+4.
REQ-019 ID decode: opcode id_instr[31:26]: 000100 beq (taken iff rs==rt), 000101 bne (taken iff rs!=rt), 000110 blez (taken iff rs signed <=0), 000111 bgtz (taken iff rs signed >0), 000010 j / 000011 jal (always taken).
REQ-020 Branch target SHALL be id_pc + 4 + {sext(id_instr[15:0]),2'b00}, modulo 2^32; jump target SHALL be {id_pc[31:28], id_instr[25:0], 2'b00}.
REQ-021 Actual next PC SHALL be the target when taken, else id_pc+4; this applies to all instructions, non-control ones being never taken.
REQ-022 redirect SHALL be id_valid & ~id_stall & (actual next PC != id_pred_pc), combinational; redirect_pc = actual next PC.
REQ-023 A non-control instruction aliasing onto a predicted-taken entry SHALL therefore raise redirect to id_pc+4; its entry SHALL be invalidated on that edge.
REQ-024 Update SHALL occur only on a clock edge with id_valid=1 and id_stall=0; no BTB or counter change otherwise.
REQ-025 Branch, entry hit: counter +1 (saturate at 2'b11) if taken, -1 (saturate at 2'b00) if not; target rewritten.
REQ-026 Branch, entry miss: if taken, allocate/overwrite with valid=1, new tag, target, counter=2'b10; if not taken, no change.
REQ-027 Jump: allocate/overwrite with valid=1, tag, target, counter=2'b11.
REQ-028 Same-cycle lookup and update at the same index: pred_pc SHALL use pre-edge contents (write-after-read).
REQ-029 branch_cnt SHALL increment by 1 per updating control instruction; mispredict_cnt by 1 per cycle with redirect=1; both wrap from 2^CNT_W-1 to 0.
REQ-030 Prediction-to-resolution latency is one stage; the block imposes no stall and has no internal pipeline registers.

Reset
REQ-031 Asserting reset SHALL asynchronously clear all valid bits, set all counters to 2'b01, and zero branch_cnt and mispredict_cnt.
REQ-032 During and immediately after reset, pred_pc SHALL equal if_pc+4 and redirect SHALL depend only on the current ID inputs.
REQ-033 Reset asserted mid-update SHALL win; no partial entry write survives.

Verification
REQ-034 After reset, if_pc=0x00400000 -> pred_pc=0x00400004; counters=0.
REQ-035 beq at id_pc=0x00400010, imm=0x0003, rs=rt=5, id_pred_pc=0x00400014 -> redirect=1, redirect_pc=0x00400020; next cycle if_pc=0x00400010 -> pred_pc=0x00400020, mispredict_cnt=1, branch_cnt=1.
REQ-036 Same bne loop entry taken 3 times then not-taken with id_pred_pc=target -> counter 10->11->11, then 10; the not-taken cycle has redirect=1, redirect_pc=id_pc+4.
REQ-037 j at id_pc=0x10000000, instr[25:0]=0x0000100 -> redirect_pc=0x10000400, entry counter=2'b11; id_stall=1 on the same inputs -> redirect=0, no update.
REQ-038 ENTRIES=4: addi at 0x00400050 aliasing taken entry of 0x00400010 with id_pred_pc=target -> redirect to 0x00400054, entry invalidated.
REQ-039 reset pulse between edges while entries are valid -> all lookups return if_pc+4 and both counters=0 without a clock edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Direct-mapped branch target buffer with 2-bit saturating counters. It
// predicts the next fetch PC in IF and resolves control flow in ID, so a
// misprediction costs exactly one flushed fetch.
//
// Ports
//   clk, reset              clock and asynchronous active-high reset
//   if_pc / pred_pc         fetch PC and its combinational next-PC prediction
//   id_valid, id_stall      ID holds a real instruction / ID is frozen
//   id_instr, id_pc         instruction in ID and its PC
//   id_pred_pc              prediction made for this instruction while in IF
//   GPR_rs_data/rt_data     forwarded register operands for branch compare
//   redirect, redirect_pc   misprediction flag and the correct next PC
//   branch_cnt              updating control instructions seen
//   mispredict_cnt          cycles with redirect asserted
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic [31:0]      pred_pc,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_pred_pc,
  input  logic [31:0]      GPR_rs_data,
  input  logic [31:0]      GPR_rt_data,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;

  logic [5:0]  opcode;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        is_branch;
  logic        is_jump;
  logic        taken;
  logic [31:0] actual_pc;
  logic        do_update;
  logic        write_entry;

  // Fetch-side lookup. Reads the array before any same-cycle update lands,
  // so an ID write to the same index only affects the following fetch.
  // Jump entries are allocated at 2'b11, so counter[1] covers them as well.
  always_comb begin
    if_idx  = if_pc[IDX_W+1:2];
    if_tag  = if_pc[31:IDX_W+2];
    if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_pc = (if_hit && cnt_q[if_idx][1]) ? target_q[if_idx] : (if_pc + 32'd4);
  end

  // ID-side decode and resolution. Anything that is not one of the
  // recognised control opcodes falls through as never taken, so a bogus
  // taken prediction on an ordinary instruction still gets redirected.
  always_comb begin
    opcode     = id_instr[31:26];
    seq_pc     = id_pc + 32'd4;
    br_target  = seq_pc + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    jmp_target = {id_pc[31:28], id_instr[25:0], 2'b00};
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    taken      = 1'b0;
    case (opcode)
      6'b000100: begin is_branch = 1'b1; taken = (GPR_rs_data == GPR_rt_data); end
      6'b000101: begin is_branch = 1'b1; taken = (GPR_rs_data != GPR_rt_data); end
      6'b000110: begin is_branch = 1'b1; taken = GPR_rs_data[31] || (GPR_rs_data == 32'd0); end
      6'b000111: begin is_branch = 1'b1; taken = !GPR_rs_data[31] && (GPR_rs_data != 32'd0); end
      6'b000010,
      6'b000011: begin is_jump = 1'b1; taken = 1'b1; end
      default:   ;
    endcase
    actual_pc   = taken ? (is_jump ? jmp_target : br_target) : seq_pc;
    do_update   = id_valid && !id_stall;
    redirect    = do_update && (actual_pc != id_pred_pc);
    redirect_pc = actual_pc;
    id_idx      = id_pc[IDX_W+1:2];
    id_tag      = id_pc[31:IDX_W+2];
    id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    write_entry = do_update && (is_jump || (is_branch && (id_hit || taken)));
  end

  // Valid bits, saturating counters and performance counters. These are
  // the only state reset touches: clearing valid is enough to make every
  // lookup miss, and a reset landing on an update edge wins outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      if (do_update) begin
        if (is_jump) begin
          valid_q[id_idx] <= 1'b1;
          cnt_q[id_idx]   <= 2'b11;
        end else if (is_branch) begin
          if (id_hit) begin
            if (taken && (cnt_q[id_idx] != 2'b11)) begin
              cnt_q[id_idx] <= cnt_q[id_idx] + 2'd1;
            end else if (!taken && (cnt_q[id_idx] != 2'b00)) begin
              cnt_q[id_idx] <= cnt_q[id_idx] - 2'd1;
            end
          end else if (taken) begin
            valid_q[id_idx] <= 1'b1;
            cnt_q[id_idx]   <= 2'b10;
          end
        end else if (redirect) begin
          valid_q[id_idx] <= 1'b0;
        end
        if (is_branch || is_jump) begin
          branch_cnt <= branch_cnt + CNT_W'(1);
        end
      end
      if (redirect) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

  // Tag and target payload. Left out of reset on purpose: an entry is only
  // ever trusted through its valid bit, which reset clears.
  always_ff @(posedge clk) begin
    if (write_entry) begin
      tag_q[id_idx]    <= id_tag;
      target_q[id_idx] <= is_jump ? jmp_target : br_target;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
// Directed bench for branch_predict_unit. A 16-entry instance carries most
// of the sequence; a 4-entry instance on the same inputs shows aliasing.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_stall;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pred_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic [31:0] pred_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  logic [31:0] pred_pc4;
  logic        redirect4;
  logic [31:0] redirect_pc4;
  logic [31:0] branch_cnt4;
  logic [31:0] mispredict_cnt4;

  int checks = 0;
  int passed = 0;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_pc(pred_pc),
    .id_valid(id_valid), .id_stall(id_stall), .id_instr(id_instr),
    .id_pc(id_pc), .id_pred_pc(id_pred_pc),
    .GPR_rs_data(rs_data), .GPR_rt_data(rt_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predict_unit #(.ENTRIES(4), .IDX_W(2)) dut4 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_pc(pred_pc4),
    .id_valid(id_valid), .id_stall(id_stall), .id_instr(id_instr),
    .id_pc(id_pc), .id_pred_pc(id_pred_pc),
    .GPR_rs_data(rs_data), .GPR_rt_data(rt_data),
    .redirect(redirect4), .redirect_pc(redirect_pc4),
    .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] ppc,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] ipc);
    id_valid   = v;
    id_stall   = s;
    id_instr   = instr;
    id_pc      = pc;
    id_pred_pc = ppc;
    rs_data    = rs;
    rt_data    = rt;
    if_pc      = ipc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400000);
    checkOutput("pred_in_reset", pred_pc, 32'h00400004);
    #10;
    reset = 1'b0;
    #1;
    checkOutput("pred_after_reset", pred_pc, 32'h00400004);
    checkOutput("redirect_after_reset", {31'b0, redirect}, 32'd0);
    checkOutput("branch_cnt_reset", branch_cnt, 32'd0);
    checkOutput("mispredict_cnt_reset", mispredict_cnt, 32'd0);

    // beq taken, first sighting: predicted fall-through, so redirect.
    applyStimulus(1, 0, 32'h10220003, 32'h00400010, 32'h00400014, 32'd5, 32'd5, 32'h00400010);
    checkOutput("beq_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h00400020);
    checkOutput("beq_war_pred", pred_pc, 32'h00400014);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400010);
    checkOutput("beq_pred_after", pred_pc, 32'h00400020);
    checkOutput("beq_mispredict_cnt", mispredict_cnt, 32'd1);
    checkOutput("beq_branch_cnt", branch_cnt, 32'd1);

    // bne loop at 0x00400030 back to 0x00400024 (index 12).
    applyStimulus(1, 0, 32'h1464FFFC, 32'h00400030, 32'h00400034, 32'd1, 32'd2, 32'h00400030);
    checkOutput("bne1_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("bne1_redirect_pc", redirect_pc, 32'h00400024);
    checkOutput("bne1_war_pred", pred_pc, 32'h00400034);
    tick();
    checkOutput("bne1_cnt", {30'b0, dut.cnt_q[12]}, 32'd2);
    applyStimulus(1, 0, 32'h1464FFFC, 32'h00400030, 32'h00400024, 32'd1, 32'd2, 32'h00400030);
    checkOutput("bne2_redirect", {31'b0, redirect}, 32'd0);
    checkOutput("bne2_pred", pred_pc, 32'h00400024);
    tick();
    checkOutput("bne2_cnt", {30'b0, dut.cnt_q[12]}, 32'd3);
    tick();
    checkOutput("bne3_cnt_sat", {30'b0, dut.cnt_q[12]}, 32'd3);
    applyStimulus(1, 0, 32'h1464FFFC, 32'h00400030, 32'h00400024, 32'd7, 32'd7, 32'h00400030);
    checkOutput("bne4_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("bne4_redirect_pc", redirect_pc, 32'h00400034);
    tick();
    checkOutput("bne4_cnt", {30'b0, dut.cnt_q[12]}, 32'd2);
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400030);
    checkOutput("bne4_pred_still_taken", pred_pc, 32'h00400024);
    checkOutput("bne_branch_cnt", branch_cnt, 32'd5);
    checkOutput("bne_mispredict_cnt", mispredict_cnt, 32'd3);

    // j at 0x10000000: first held by a stall, then released.
    applyStimulus(1, 1, 32'h08000100, 32'h10000000, 32'h10000004, 32'h0, 32'h0, 32'h10000000);
    checkOutput("j_stall_redirect", {31'b0, redirect}, 32'd0);
    tick();
    checkOutput("j_stall_branch_cnt", branch_cnt, 32'd5);
    checkOutput("j_stall_pred", pred_pc, 32'h10000004);
    applyStimulus(1, 0, 32'h08000100, 32'h10000000, 32'h10000004, 32'h0, 32'h0, 32'h10000000);
    checkOutput("j_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("j_redirect_pc", redirect_pc, 32'h10000400);
    tick();
    checkOutput("j_cnt", {30'b0, dut.cnt_q[0]}, 32'd3);
    checkOutput("j_pred", pred_pc, 32'h10000400);
    checkOutput("j_branch_cnt", branch_cnt, 32'd6);

    // blez taken on a negative operand, then bgtz not taken on the same PC.
    applyStimulus(1, 0, 32'h19000002, 32'h00400040, 32'h00400044, 32'hFFFFFFFF, 32'h0, 32'h00400040);
    checkOutput("blez_redirect_pc", redirect_pc, 32'h0040004C);
    checkOutput("blez_redirect", {31'b0, redirect}, 32'd1);
    tick();
    checkOutput("blez_pred", pred_pc, 32'h0040004C);
    applyStimulus(1, 0, 32'h1D000002, 32'h00400040, 32'h0040004C, 32'hFFFFFFFF, 32'h0, 32'h00400040);
    checkOutput("bgtz_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("bgtz_redirect_pc", redirect_pc, 32'h00400044);
    tick();
    checkOutput("bgtz_cnt", {30'b0, dut.cnt_q[0]}, 32'd1);
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400040);
    checkOutput("bgtz_pred", pred_pc, 32'h00400044);
    checkOutput("bgtz_branch_cnt", branch_cnt, 32'd8);
    checkOutput("bgtz_mispredict_cnt", mispredict_cnt, 32'd6);

    // Reset pulse between edges while entries are live.
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400010);
    checkOutput("pre_pulse_pred", pred_pc, 32'h00400020);
    reset = 1'b1;
    applyStimulus(1, 0, 32'h10220003, 32'h00400010, 32'h00400014, 32'd5, 32'd5, 32'h00400010);
    checkOutput("pulse_pred", pred_pc, 32'h00400014);
    checkOutput("pulse_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("pulse_branch_cnt", branch_cnt, 32'd0);
    checkOutput("pulse_mispredict_cnt", mispredict_cnt, 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400030);
    reset = 1'b0;
    #1;
    checkOutput("pulse_pred_loop", pred_pc, 32'h00400034);

    // 4-entry aliasing: addi at 0x00400050 lands on the beq entry of 0x00400010.
    applyStimulus(1, 0, 32'h10220003, 32'h00400010, 32'h00400014, 32'd5, 32'd5, 32'h00400010);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400010);
    checkOutput("alias_pre_pred4", pred_pc4, 32'h00400020);
    applyStimulus(1, 0, 32'h20000001, 32'h00400050, 32'h00400020, 32'h0, 32'h0, 32'h00400010);
    checkOutput("alias_redirect4", {31'b0, redirect4}, 32'd1);
    checkOutput("alias_redirect_pc4", redirect_pc4, 32'h00400054);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00400010);
    checkOutput("alias_invalidated4", pred_pc4, 32'h00400014);
    checkOutput("alias_branch_cnt4", branch_cnt4, 32'd1);
    checkOutput("alias_mispredict_cnt4", mispredict_cnt4, 32'd2);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
